// File: rtl/adc_capture_ctrl.sv
// ADC capture controller: generates clk_ADC/ADC_En from clk_100MHz, discards pipeline-latency samples,
// averages 2^AVG_LOG2 strobes per channel and hands results out through a valid/ready register.
module adc_capture_ctrl #(
  parameter int DATA_W   = 8,
  parameter int NCH      = 1,
  parameter int CLK_DIV  = 100,
  parameter int AVG_LOG2 = 0,
  parameter int LAT      = 3,
  parameter int CNT_W    = 16
) (
  input  logic                    clk_100MHz,
  input  logic                    Rst,
  output logic                    clk_ADC,
  output logic                    ADC_En,
  input  logic [NCH*DATA_W-1:0]   adc_data,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    continuous,
  input  logic [CNT_W-1:0]        num_samples,
  output logic [NCH*DATA_W-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int LAT_W = (LAT > 0) ? $clog2(LAT + 1) : 1;
  localparam int AVG_W = AVG_LOG2 + 1;
  localparam int AVG_N = 1 << AVG_LOG2;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] HALF_V  = DIV_W'(CLK_DIV / 2);
  localparam logic [LAT_W-1:0] LAT_V   = LAT_W'(LAT);
  localparam logic [AVG_W-1:0] AVG_MAX = AVG_W'(AVG_N - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_nx;
  logic [DIV_W-1:0]   cnt, cnt_nx;
  logic [LAT_W-1:0]   disc_cnt;
  logic [AVG_W-1:0]   avg_cnt;
  logic [CNT_W-1:0]   res_cnt;
  logic [CNT_W-1:0]   num_lat;
  logic               cont_lat;
  logic [ACC_W-1:0]   acc [NCH];
  logic [ACC_W-1:0]   sum [NCH];
  logic               start_ok, strobe, acc_en, res_en, last_res;

  assign busy   = (state == RUN);
  assign ADC_En = (state != RUN);

  always_comb begin
    start_ok = start && !stop && (continuous || (num_samples != '0));
    // stop suppresses the strobe so an abort never emits a result on its own edge
    strobe   = (state == RUN) && !stop && (cnt == DIV_MAX);
    acc_en   = strobe && (disc_cnt == LAT_V);
    res_en   = acc_en && (avg_cnt == AVG_MAX);
    last_res = res_en && !cont_lat && (res_cnt == (num_lat - 1'b1));

    for (int unsigned i = 0; i < NCH; i++)
      sum[i] = acc[i] + ACC_W'(adc_data[i*DATA_W +: DATA_W]);

    state_nx = state;
    case (state)
      IDLE: if (start_ok) state_nx = RUN;
      RUN:  if (stop || last_res) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    cnt_nx = '0;
    if ((state == RUN) && (state_nx == RUN))
      cnt_nx = (cnt == DIV_MAX) ? '0 : cnt + 1'b1;
  end

  always_ff @(posedge clk_100MHz or negedge Rst) begin
    if (!Rst) begin
      state     <= IDLE;
      cnt       <= '0;
      clk_ADC   <= 1'b0;
      disc_cnt  <= '0;
      avg_cnt   <= '0;
      res_cnt   <= '0;
      num_lat   <= '0;
      cont_lat  <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
      for (int unsigned i = 0; i < NCH; i++) acc[i] <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      clk_ADC <= (state_nx == RUN) && (cnt_nx >= HALF_V);
      done    <= last_res;

      if ((state == IDLE) && start_ok) begin
        cont_lat <= continuous;
        num_lat  <= num_samples;
        overrun  <= 1'b0;
      end

      // leaving RUN (stop or final result) drops any partial accumulation
      if (state_nx != RUN) begin
        disc_cnt <= '0;
        avg_cnt  <= '0;
        res_cnt  <= '0;
        for (int unsigned i = 0; i < NCH; i++) acc[i] <= '0;
      end else if (strobe) begin
        if (!acc_en) begin
          disc_cnt <= disc_cnt + 1'b1;
        end else if (res_en) begin
          avg_cnt <= '0;
          res_cnt <= res_cnt + 1'b1;
          for (int unsigned i = 0; i < NCH; i++) acc[i] <= '0;
        end else begin
          avg_cnt <= avg_cnt + 1'b1;
          for (int unsigned i = 0; i < NCH; i++) acc[i] <= sum[i];
        end
      end

      if (res_en) begin
        if (!out_valid || out_ready) begin
          out_valid <= 1'b1;
          for (int unsigned i = 0; i < NCH; i++)
            out_data[i*DATA_W +: DATA_W] <= sum[i][AVG_LOG2 +: DATA_W];
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl: a default instance (ramp ADC) and a 2-channel averaging
// instance with a fast divider (alternating 1/2 on channel 0, constant 0xFF on channel 1).
module tb_adc_capture_ctrl;

  logic clk;
  logic rst_n;

  logic        clk_adc_a, adc_en_a, start_a, stop_a, cont_a, ov_a, rdy_a, busy_a, done_a, ovr_a;
  logic [7:0]  adc_a, od_a;
  logic [15:0] ns_a;

  logic        clk_adc_b, adc_en_b, start_b, stop_b, cont_b, ov_b, rdy_b, busy_b, done_b, ovr_b;
  logic [15:0] adc_b, od_b;
  logic [15:0] ns_b;

  int passed = 0;
  int total  = 0;
  int n;

  adc_capture_ctrl dut_a (
    .clk_100MHz(clk), .Rst(rst_n), .clk_ADC(clk_adc_a), .ADC_En(adc_en_a),
    .adc_data(adc_a), .start(start_a), .stop(stop_a), .continuous(cont_a),
    .num_samples(ns_a), .out_data(od_a), .out_valid(ov_a), .out_ready(rdy_a),
    .busy(busy_a), .done(done_a), .overrun(ovr_a)
  );

  adc_capture_ctrl #(.DATA_W(8), .NCH(2), .CLK_DIV(4), .AVG_LOG2(2), .LAT(1), .CNT_W(16)) dut_b (
    .clk_100MHz(clk), .Rst(rst_n), .clk_ADC(clk_adc_b), .ADC_En(adc_en_b),
    .adc_data(adc_b), .start(start_b), .stop(stop_b), .continuous(cont_b),
    .num_samples(ns_b), .out_data(od_b), .out_valid(ov_b), .out_ready(rdy_b),
    .busy(busy_b), .done(done_b), .overrun(ovr_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ADC A: value counts clk_ADC rising edges within a run, so strobe k sees value k
  initial begin
    adc_a = 8'd0;
    forever begin
      @(posedge clk_adc_a or negedge busy_a);
      if (!busy_a) adc_a = 8'd0;
      else         adc_a = adc_a + 8'd1;
    end
  end

  // ADC B: channel 0 alternates 0x01/0x02 per ADC clock, channel 1 fixed at 0xFF
  initial begin
    adc_b = 16'hFF02;
    forever begin
      @(posedge clk_adc_b);
      adc_b[7:0] = (adc_b[7:0] == 8'h01) ? 8'h02 : 8'h01;
    end
  end

  task automatic step(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic wait_valid_a(input int budget, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!ov_a && cnt < budget);
  endtask

  task automatic wait_valid_b(input int budget, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!ov_b && cnt < budget);
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start_a = 0; stop_a = 0; cont_a = 0; ns_a = 16'd0; rdy_a = 1'b1;
    start_b = 0; stop_b = 0; cont_b = 0; ns_b = 16'd0; rdy_b = 1'b1;

    // reset state
    step(2);
    check("rst_busy",    busy_a,    1'b0);
    check("rst_adc_en",  adc_en_a,  1'b1);
    check("rst_clk_adc", clk_adc_a, 1'b0);
    check("rst_valid",   ov_a,      1'b0);
    check("rst_data",    od_a,      8'h00);
    check("rst_done",    done_a,    1'b0);
    check("rst_overrun", ovr_a,     1'b0);
    check("rst_b_en",    adc_en_b,  1'b1);
    rst_n = 1'b1;
    step(2);
    check("idle_clk_adc", clk_adc_a, 1'b0);

    // averaging: 4 strobes of 1/2 alternating -> 0x01; 0xFF constant -> 0xFF; 2 results single-shot
    ns_b = 16'd2; cont_b = 1'b0;
    start_b = 1'b1; step(1); start_b = 1'b0;
    check("b_busy", busy_b, 1'b1);
    wait_valid_b(60, n);
    check("b_first_lat", n, 20);
    check("b_avg_data1", od_b, 16'hFF01);
    check("b_ovr", ovr_b, 1'b0);
    wait_valid_b(60, n);
    check("b_second_lat", n, 16);
    check("b_avg_data2", od_b, 16'hFF01);
    check("b_done", done_b, 1'b1);
    check("b_busy_fall", busy_b, 1'b0);
    check("b_clk_idle", clk_adc_b, 1'b0);

    // single-shot, num_samples=4, clk_ADC shape and results from strobes 4..7
    cont_a = 1'b0; ns_a = 16'd4; rdy_a = 1'b1;
    pulse_start_a();
    check("ss_busy",   busy_a,    1'b1);
    check("ss_adc_en", adc_en_a,  1'b0);
    check("ss_clk_c0", clk_adc_a, 1'b0);
    step(49);
    check("ss_clk_c49", clk_adc_a, 1'b0);
    step(1);
    check("ss_clk_c50", clk_adc_a, 1'b1);
    step(49);
    check("ss_clk_c99", clk_adc_a, 1'b1);
    step(1);
    check("ss_clk_wrap", clk_adc_a, 1'b0);
    check("ss_no_early_result", ov_a, 1'b0);
    for (int r = 0; r < 4; r++) begin
      wait_valid_a(400, n);
      check("ss_latency", n, (r == 0) ? 300 : 100);
      check("ss_data", od_a, 8'(4 + r));
      check("ss_done", done_a, (r == 3) ? 1'b1 : 1'b0);
      check("ss_busy_run", busy_a, (r == 3) ? 1'b0 : 1'b1);
    end
    step(1);
    check("ss_done_pulse", done_a, 1'b0);
    check("ss_valid_clear", ov_a, 1'b0);
    check("ss_adc_en_idle", adc_en_a, 1'b1);

    // backpressure: first result held, second dropped with overrun
    cont_a = 1'b1; rdy_a = 1'b0;
    pulse_start_a();
    wait_valid_a(600, n);
    check("bp_latency", n, 400);
    check("bp_data1", od_a, 8'd4);
    check("bp_ovr0", ovr_a, 1'b0);
    step(100);
    check("bp_valid_held", ov_a, 1'b1);
    check("bp_data_kept", od_a, 8'd4);
    check("bp_overrun", ovr_a, 1'b1);

    // stop mid-run
    step(30);
    stop_a = 1'b1; step(1); stop_a = 1'b0;
    check("stop_busy", busy_a, 1'b0);
    check("stop_clk_adc", clk_adc_a, 1'b0);
    check("stop_adc_en", adc_en_a, 1'b1);
    check("stop_no_done", done_a, 1'b0);
    check("stop_pending_kept", ov_a, 1'b1);
    check("stop_ovr_sticky", ovr_a, 1'b1);
    rdy_a = 1'b1; step(1); rdy_a = 1'b0;
    check("stop_drain", ov_a, 1'b0);
    step(300);
    check("stop_no_result", ov_a, 1'b0);
    check("stop_still_idle", busy_a, 1'b0);

    // start together with stop, and single-shot with zero count, are both refused
    start_a = 1'b1; stop_a = 1'b1; step(1); start_a = 1'b0; stop_a = 1'b0;
    check("startstop_idle", busy_a, 1'b0);
    check("startstop_clk", clk_adc_a, 1'b0);
    check("startstop_ovr", ovr_a, 1'b1);
    cont_a = 1'b0; ns_a = 16'd0;
    pulse_start_a();
    check("zero_ns_idle", busy_a, 1'b0);

    // simultaneous accept on the result-forming cycle
    cont_a = 1'b1; ns_a = 16'd4;
    pulse_start_a();
    check("sa_busy", busy_a, 1'b1);
    check("sa_ovr_cleared", ovr_a, 1'b0);
    wait_valid_a(600, n);
    check("sa_data1", od_a, 8'd4);
    step(99);
    rdy_a = 1'b1;
    step(1);
    check("sa_valid", ov_a, 1'b1);
    check("sa_data2", od_a, 8'd5);
    check("sa_ovr", ovr_a, 1'b0);
    step(1);
    check("sa_consumed", ov_a, 1'b0);
    stop_a = 1'b1; step(1); stop_a = 1'b0;
    check("sa_stop", busy_a, 1'b0);

    // asynchronous reset mid-run, no clock edge needed
    rdy_a = 1'b0;
    pulse_start_a();
    wait_valid_a(600, n);
    step(60);
    check("mr_clk_high", clk_adc_a, 1'b1);
    check("mr_busy", busy_a, 1'b1);
    check("mr_valid", ov_a, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_clk_adc", clk_adc_a, 1'b0);
    check("mr_adc_en", adc_en_a, 1'b1);
    check("mr_valid_clr", ov_a, 1'b0);
    check("mr_busy_clr", busy_a, 1'b0);
    check("mr_data_clr", od_a, 8'h00);
    check("mr_b_busy", busy_b, 1'b0);
    check("mr_b_flags", {done_b, ovr_b}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    step(2);
    check("post_rst_idle", busy_a, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
